// File: rtl/ej32_pkg.sv
// Shared eJ32 types: AU stack opcodes, stack-controller states and default stack depth.
package ej32_pkg;

    typedef enum logic [1:0] {
        sNOP  = 2'd0,
        sPUSH = 2'd1,
        sPOP  = 2'd2,
        sMOVE = 2'd3
    } stack_op;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } ss_state_t;

    localparam int SS_DEPTH_DFLT = 32;

endpackage

// File: rtl/ej32_ss_ebr.sv
// Single-port synchronous-read stack RAM (SS_DEPTH-1 words), placed beside ej32_ss_ctl in the AU wrapper.
module ej32_ss_ebr
    import ej32_pkg::*;
#(
    parameter int SS_DEPTH = SS_DEPTH_DFLT,
    parameter int DSZ      = 32,
    parameter int ASZ      = $clog2(SS_DEPTH)
) (
    input  logic           clk,
    input  logic [ASZ-1:0] a,
    input  logic           we,
    input  logic [DSZ-1:0] d,
    output logic [DSZ-1:0] q
);

    logic [DSZ-1:0] mem [SS_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[a] <= d;
        q <= mem[a];
    end

endmodule

// File: rtl/ej32_ss_ctl.sv
// eJ32 data-stack controller: caches NOS in s_r and spills deeper entries to an external EBR.
// Build option EJ32_SS_PREFETCH_EN caches entry cnt-2 as well, giving stall-free single-cycle POPs.
module ej32_ss_ctl
    import ej32_pkg::*;
#(
    parameter int SS_DEPTH = SS_DEPTH_DFLT,
    parameter int DSZ      = 32,
    parameter int ASZ      = $clog2(SS_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [1:0]     op,
    input  logic [DSZ-1:0] t,
    output logic [DSZ-1:0] s_o,
    output logic           bsy_o,
    output logic [ASZ:0]   sp_o,
    output logic           ovf_o,
    output logic           udf_o,
    output logic [ASZ-1:0] mem_a,
    output logic           mem_we,
    output logic [DSZ-1:0] mem_d,
    input  logic [DSZ-1:0] mem_q
);

    localparam logic [ASZ:0] FULL  = (ASZ+1)'(SS_DEPTH);
    localparam logic [ASZ:0] ONE   = (ASZ+1)'(1);
    localparam logic [ASZ:0] TWO   = (ASZ+1)'(2);

    stack_op        op_e;
    logic [ASZ:0]   cnt;
    logic [DSZ-1:0] s_r;
    logic           ovf_r;
    logic           udf_r;
    logic           accept;

    assign op_e  = stack_op'(op);
    assign sp_o  = cnt;
    assign s_o   = s_r;
    assign ovf_o = ovf_r;
    assign udf_o = udf_r;
    assign mem_d = s_r;

`ifdef EJ32_SS_PREFETCH_EN

    localparam logic [ASZ:0] THREE = (ASZ+1)'(3);

    logic [DSZ-1:0] p_r;
    logic           p_v;
    logic           rd_pend;

    assign accept = en;
    assign bsy_o  = 1'b0;

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        if (accept) begin
            case (op_e)
                sPUSH: if (cnt != '0 && cnt != FULL) begin
                    mem_we = 1'b1;
                    mem_a  = ASZ'(cnt - ONE);
                end
                sPOP:  if (cnt >= THREE)
                    mem_a = ASZ'(cnt - THREE);
                default: ;
            endcase
        end
    end

    // Later op assignments override the background capture of a completed read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            s_r     <= '0;
            p_r     <= '0;
            p_v     <= 1'b0;
            rd_pend <= 1'b0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            if (rd_pend) begin
                rd_pend <= 1'b0;
                if (!p_v) begin
                    p_r <= mem_q;
                    p_v <= 1'b1;
                end
            end
            if (accept) begin
                case (op_e)
                    sPUSH: begin
                        if (cnt == FULL) begin
                            ovf_r <= 1'b1;
                        end else begin
                            s_r     <= t;
                            cnt     <= cnt + ONE;
                            p_r     <= s_r;
                            p_v     <= (cnt != '0);
                            rd_pend <= 1'b0;
                        end
                    end
                    sPOP: begin
                        if (cnt >= TWO) begin
                            s_r     <= p_v ? p_r : mem_q;
                            cnt     <= cnt - ONE;
                            p_v     <= 1'b0;
                            rd_pend <= (cnt >= THREE);
                        end else if (cnt == ONE) begin
                            s_r     <= '0;
                            cnt     <= '0;
                            p_v     <= 1'b0;
                            rd_pend <= 1'b0;
                        end else begin
                            udf_r <= 1'b1;
                        end
                    end
                    sMOVE: begin
                        if (cnt == '0)
                            udf_r <= 1'b1;
                        else
                            s_r <= t;
                    end
                    default: ;
                endcase
            end
        end
    end

`else

    ss_state_t state;

    assign accept = en && (state == IDLE);
    assign bsy_o  = (state == FILL);

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        if (accept) begin
            case (op_e)
                sPUSH: if (cnt != '0 && cnt != FULL) begin
                    mem_we = 1'b1;
                    mem_a  = ASZ'(cnt - ONE);
                end
                sPOP:  if (cnt >= TWO)
                    mem_a = ASZ'(cnt - TWO);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            s_r   <= '0;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    case (op_e)
                        sPUSH: begin
                            if (cnt == FULL) begin
                                ovf_r <= 1'b1;
                            end else begin
                                s_r <= t;
                                cnt <= cnt + ONE;
                            end
                        end
                        sPOP: begin
                            if (cnt >= TWO) begin
                                cnt   <= cnt - ONE;
                                state <= FILL;
                            end else if (cnt == ONE) begin
                                cnt <= '0;
                                s_r <= '0;
                            end else begin
                                udf_r <= 1'b1;
                            end
                        end
                        sMOVE: begin
                            if (cnt == '0)
                                udf_r <= 1'b1;
                            else
                                s_r <= t;
                        end
                        default: ;
                    endcase
                end
                // Refill completes even with en low; read data was addressed in the accepting cycle.
                FILL: begin
                    s_r   <= mem_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_ej32_ss_ctl.sv
// Self-checking bench for ej32_ss_ctl with its EBR; a reference stack queue feeds a scoreboard.
module tb_ej32_ss_ctl;
    import ej32_pkg::*;

    localparam int DEPTH = 32;
    localparam int DSZ   = 32;
    localparam int ASZ   = 5;

    logic           clk;
    logic           rst;
    logic           en;
    logic [1:0]     op;
    logic [DSZ-1:0] t;
    logic [DSZ-1:0] s_o;
    logic           bsy_o;
    logic [ASZ:0]   sp_o;
    logic           ovf_o;
    logic           udf_o;
    logic [ASZ-1:0] mem_a;
    logic           mem_we;
    logic [DSZ-1:0] mem_d;
    logic [DSZ-1:0] mem_q;

    typedef struct {
        logic [ASZ:0]   sp;
        logic [DSZ-1:0] s;
        logic           ovf;
        logic           udf;
    } exp_t;

    exp_t           sb[$];
    logic [DSZ-1:0] model[$];
    logic           m_ovf;
    logic           m_udf;
    int             n_cmp;
    int             n_bad;

    ej32_ss_ctl #(.SS_DEPTH(DEPTH), .DSZ(DSZ), .ASZ(ASZ)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .t(t),
        .s_o(s_o), .bsy_o(bsy_o), .sp_o(sp_o), .ovf_o(ovf_o), .udf_o(udf_o),
        .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
    );

    ej32_ss_ebr #(.SS_DEPTH(DEPTH), .DSZ(DSZ), .ASZ(ASZ)) u_ebr (
        .clk(clk), .a(mem_a), .we(mem_we), .d(mem_d), .q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        op  = sNOP;
        t   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model.delete();
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic do_op(input stack_op o, input logic [DSZ-1:0] v, input logic e = 1'b1);
        exp_t x;
        int   pre;
        logic exp_we;
        logic refill;
        pre    = model.size();
        exp_we = e && (o == sPUSH) && pre > 0 && pre < DEPTH;
        refill = e && (o == sPOP) && pre >= 2;
        en = e;
        op = o;
        t  = v;
        if (e) begin
            case (o)
                sPUSH: if (pre == DEPTH) m_ovf = 1'b1; else model.push_back(v);
                sPOP:  if (pre == 0) m_udf = 1'b1; else void'(model.pop_back());
                sMOVE: if (pre == 0) m_udf = 1'b1; else model[pre-1] = v;
                default: ;
            endcase
        end
        x.sp  = (ASZ+1)'(model.size());
        x.s   = (model.size() > 0) ? model[model.size()-1] : '0;
        x.ovf = m_ovf;
        x.udf = m_udf;
        sb.push_back(x);
        #1;
        n_cmp++;
        if (mem_we !== exp_we) begin
            n_bad++;
            $display("FAIL mem_we op=%0d pre=%0d: got %b want %b", o, pre, mem_we, exp_we);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        op = sNOP;
        n_cmp++;
`ifdef EJ32_SS_PREFETCH_EN
        if (bsy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bsy_accept: got %b want 0", bsy_o);
        end
`else
        if (bsy_o !== refill) begin
            n_bad++;
            $display("FAIL bsy_accept: got %b want %b", bsy_o, refill);
        end
        if (refill) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bsy_o !== 1'b0) begin
                n_bad++;
                $display("FAIL bsy_fill_end: got %b want 0", bsy_o);
            end
        end
`endif
        x = sb.pop_front();
        n_cmp++;
        if (sp_o !== x.sp) begin
            n_bad++;
            $display("FAIL sp op=%0d: got %0d want %0d", o, sp_o, x.sp);
        end
        n_cmp++;
        if (s_o !== x.s) begin
            n_bad++;
            $display("FAIL s op=%0d: got %h want %h", o, s_o, x.s);
        end
        n_cmp++;
        if (ovf_o !== x.ovf || udf_o !== x.udf) begin
            n_bad++;
            $display("FAIL flags op=%0d: got ovf=%b udf=%b want ovf=%b udf=%b", o, ovf_o, udf_o, x.ovf, x.udf);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (sp_o !== '0 || s_o !== '0 || bsy_o !== 1'b0 || ovf_o !== 1'b0 || udf_o !== 1'b0 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got sp=%0d s=%h bsy=%b ovf=%b udf=%b we=%b want all 0",
                     sp_o, s_o, bsy_o, ovf_o, udf_o, mem_we);
        end
    endtask

    task automatic test_push_pop();
        do_op(sPUSH, 32'h11);
        do_op(sPUSH, 32'h22);
        do_op(sPUSH, 32'h33);
        n_cmp++;
        if (u_ebr.mem[0] !== 32'h11 || u_ebr.mem[1] !== 32'h22) begin
            n_bad++;
            $display("FAIL ebr_after_push3: got %h %h want 11 22", u_ebr.mem[0], u_ebr.mem[1]);
        end
        do_op(sPOP, '0);
        do_op(sPOP, '0);
        do_op(sPOP, '0);
    endtask

    task automatic test_underflow();
        do_reset();
        do_op(sPOP, '0);
        do_reset();
        do_op(sMOVE, 32'h55);
    endtask

    task automatic test_move();
        do_reset();
        do_op(sPUSH, 32'h1);
        do_op(sPUSH, 32'h2);
        do_op(sMOVE, 32'hDEAD);
        do_op(sPOP, '0);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_op(sPUSH, DSZ'(i));
        do_op(sPUSH, 32'h99);
        n_cmp++;
        if (u_ebr.mem[30] !== 32'd30) begin
            n_bad++;
            $display("FAIL ebr30_after_ovf: got %h want %h", u_ebr.mem[30], 32'd30);
        end
    endtask

    task automatic test_back_to_back();
        do_op(sPOP, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            do_op(sPOP, '0);
        do_op(sPOP, '0);
        do_op(sPUSH, 32'hA5);
        do_op(sPUSH, 32'h5A);
        do_op(sPUSH, 32'h3C);
        do_op(sPOP, '0);
        do_op(sPUSH, 32'h77);
        do_op(sPOP, '0);
        do_op(sPOP, '0);
    endtask

    task automatic test_reset_fill();
        do_reset();
        do_op(sPOP, '0);
        do_op(sPUSH, 32'h1);
        do_op(sPUSH, 32'h2);
        do_op(sPUSH, 32'h3);
        en  = 1'b1;
        op  = sPOP;
        @(posedge clk);
        #1;
        op  = sNOP;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        n_cmp++;
        if (sp_o !== '0 || s_o !== '0 || bsy_o !== 1'b0 || ovf_o !== 1'b0 || udf_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_in_fill: got sp=%0d s=%h bsy=%b ovf=%b udf=%b want all 0",
                     sp_o, s_o, bsy_o, ovf_o, udf_o);
        end
        model.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        do_op(sPUSH, 32'h44);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b0;
        en    = 1'b0;
        op    = sNOP;
        t     = '0;
        test_reset();
        test_push_pop();
        test_underflow();
        test_move();
        test_overflow();
        test_back_to_back();
        test_reset_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
